// File: rtl/delayw_ctrl_pkg.sv
// Shared types and pointer arithmetic for the programmable sample delay line.
package delayw_ctrl_pkg;

    localparam int ADDR_W  = 5;
    localparam int DELAY_W = ADDR_W;

    typedef enum logic [1:0] {
        FILL,
        RUN,
        RECFG
    } state_t;

    typedef enum logic [1:0] {
        SEL_ZERO,
        SEL_RAM,
        SEL_BYP
    } out_sel_t;

    // Circular-buffer subtract: (ptr - d) mod 2**aw.
    function automatic int unsigned ptr_sub(int unsigned ptr, int unsigned d, int unsigned aw);
        int unsigned mask;
        mask = (32'd1 << aw) - 32'd1;
        return (ptr - d) & mask;
    endfunction

endpackage

// File: rtl/delayw_ctrl_if.sv
// Sample and config handshake bundle for the delay-line sequencer.
interface delayw_ctrl_if
    import delayw_ctrl_pkg::*;
#(
    parameter int DW = 8,
    parameter int AW = DELAY_W
);
    logic          i_cfg_valid;
    logic [AW-1:0] i_cfg_delay;
    logic          o_cfg_ready;
    logic          i_valid;
    logic [DW-1:0] i_data;
    logic          o_ready;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic          o_primed;

    modport master (
        output i_cfg_valid, i_cfg_delay, i_valid, i_data,
        input  o_cfg_ready, o_ready, o_valid, o_data, o_primed
    );

    modport slave (
        input  i_cfg_valid, i_cfg_delay, i_valid, i_data,
        output o_cfg_ready, o_ready, o_valid, o_data, o_primed
    );
endinterface

// File: rtl/delayw_ctrl_ram.sv
// Simple dual-port sample buffer: synchronous write, registered read, no bypass.
module delayw_ctrl_ram #(
    parameter int DW = 8,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/delayw_ctrl.sv
// Programmable-length delay-line sequencer (FILL/RUN/RECFG).
// Build option: DELAYW_CTRL_ZERO_FILL_EN emits zero samples while the buffer fills.
module delayw_ctrl
    import delayw_ctrl_pkg::*;
#(
    parameter int DW            = 8,
    parameter int AW            = ADDR_W,
    parameter int DEFAULT_DELAY = 4
) (
    input logic          i_clk,
    input logic          i_reset,
    delayw_ctrl_if.slave bus
);
    state_t        state, state_nxt;
    logic [AW-1:0] wr_ptr, delay, pend_delay, fill_cnt, rd_addr;
    logic          accept, cfg_acc, emit_run, fill_acc, rd_en, fill_done;
    logic [DW-1:0] ram_q, byp_p1;
    logic          vld_p1, primed_p1;
    out_sel_t      sel_p1;

    assign bus.o_ready     = (state != RECFG);
    assign bus.o_cfg_ready = (state != RECFG);
    assign accept    = bus.i_valid & bus.o_ready;
    assign cfg_acc   = bus.i_cfg_valid & bus.o_cfg_ready;
    assign emit_run  = accept & (state == RUN);
    assign fill_acc  = accept & (state == FILL);
    assign rd_en     = emit_run & (delay != '0);
    assign rd_addr   = AW'(ptr_sub(32'(wr_ptr), 32'(delay), AW));
    assign fill_done = (({1'b0, fill_cnt} + (AW+1)'(1)) == {1'b0, delay});

    // A config accept wins over priming completion so the new delay refills.
    always_comb begin
        state_nxt = state;
        case (state)
            FILL: begin
                if (cfg_acc)                    state_nxt = RECFG;
                else if (delay == '0)           state_nxt = RUN;
                else if (fill_acc && fill_done) state_nxt = RUN;
            end
            RUN: begin
                if (cfg_acc) state_nxt = RECFG;
            end
            RECFG: state_nxt = (pend_delay == '0) ? RUN : FILL;
            default: state_nxt = FILL;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= FILL;
            wr_ptr     <= '0;
            fill_cnt   <= '0;
            delay      <= AW'(DEFAULT_DELAY);
            pend_delay <= '0;
            vld_p1     <= 1'b0;
            primed_p1  <= 1'b0;
            sel_p1     <= SEL_ZERO;
        end else begin
            state <= state_nxt;
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (state == RECFG) begin
                delay    <= pend_delay;
                fill_cnt <= '0;
            end else if (fill_acc && (fill_cnt != delay)) begin
                fill_cnt <= fill_cnt + AW'(1);
            end
            if (cfg_acc) pend_delay <= bus.i_cfg_delay;
            primed_p1 <= (state == RUN);
`ifdef DELAYW_CTRL_ZERO_FILL_EN
            vld_p1 <= emit_run | fill_acc;
            if (fill_acc) sel_p1 <= SEL_ZERO;
`else
            vld_p1 <= emit_run;
`endif
            if (emit_run) sel_p1 <= (delay == '0) ? SEL_BYP : SEL_RAM;
        end
    end

    // D=0 bypass: the RAM has no read-during-write path, so the sample is carried here.
    always_ff @(posedge i_clk) begin
        if (emit_run && (delay == '0)) byp_p1 <= bus.i_data;
    end

    delayw_ctrl_ram #(.DW(DW), .AW(AW)) u_ram (
        .clk   (i_clk),
        .we    (accept & ~i_reset),
        .waddr (wr_ptr),
        .wdata (bus.i_data),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (ram_q)
    );

    // Output stage: selects are only updated on emitting accepts, so o_data holds when idle.
    always_comb begin
        case (sel_p1)
            SEL_RAM: bus.o_data = ram_q;
            SEL_BYP: bus.o_data = byp_p1;
            default: bus.o_data = '0;
        endcase
    end

    assign bus.o_valid  = vld_p1;
    assign bus.o_primed = primed_p1;
endmodule

// File: tb/tb_delayw_ctrl.sv
// Self-checking bench for delayw_ctrl: directed scenarios plus randomized traffic vs a sample-history model.
module tb_delayw_ctrl;
    localparam int DW  = 8;
    localparam int AW  = 5;
    localparam int DEF = 4;
`ifdef DELAYW_CTRL_ZERO_FILL_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    delayw_ctrl_if #(.DW(DW), .AW(AW)) bus ();

    delayw_ctrl #(.DW(DW), .AW(AW), .DEFAULT_DELAY(DEF)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: mode 0=FILL 1=RUN 2=RECFG; hist holds every sample accepted since reset.
    int         m_mode, m_d, m_fill, m_pend;
    logic [7:0] hist[$];
    logic       n_valid, n_primed;
    logic [7:0] n_data;
    logic       e_valid, e_primed, e_ready;
    logic [7:0] e_data;
    logic [7:0] got_q[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_cycle(bit v, logic [7:0] d, bit cv, logic [4:0] cd, bit r);
        bit acc, cacc;
        if (r) begin
            m_mode = 0; m_d = DEF; m_fill = 0; m_pend = 0;
            hist.delete();
            n_valid = 1'b0; n_data = 8'h00; n_primed = 1'b0;
            return;
        end
        acc      = v  && (m_mode != 2);
        cacc     = cv && (m_mode != 2);
        n_primed = (m_mode == 1);
        n_valid  = 1'b0;
        if (acc) begin
            hist.push_back(d);
            if (m_mode == 1) begin
                n_valid = 1'b1;
                n_data  = hist[hist.size() - 1 - m_d];
            end else if (ZF) begin
                n_valid = 1'b1;
                n_data  = 8'h00;
            end
        end
        if (m_mode == 2) begin
            m_d = m_pend; m_fill = 0;
            m_mode = (m_d == 0) ? 1 : 0;
        end else if (cacc) begin
            m_pend = int'(cd); m_mode = 2;
        end else if (m_mode == 0) begin
            if (acc) m_fill++;
            if (m_fill >= m_d) m_mode = 1;
        end
    endtask

    task automatic cyc(bit v, logic [7:0] d, bit cv, logic [4:0] cd, bit r);
        rst             = r;
        bus.i_valid     = v;
        bus.i_data      = d;
        bus.i_cfg_valid = cv;
        bus.i_cfg_delay = cd;
        model_cycle(v, d, cv, cd, r);
        @(posedge clk);
        #1;
        e_valid  = n_valid;
        e_data   = n_data;
        e_primed = n_primed;
        e_ready  = (m_mode != 2);
    endtask

    task automatic feed(logic [7:0] d);
        cyc(1'b1, d, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic idle(int n);
        repeat (n) cyc(1'b0, 8'h00, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic cfg(logic [4:0] d);
        cyc(1'b0, 8'h00, 1'b1, d, 1'b0);
        idle(1);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("o_valid",     32'(bus.o_valid),     32'(e_valid));
            chk("o_data",      32'(bus.o_data),      32'(e_data));
            chk("o_primed",    32'(bus.o_primed),    32'(e_primed));
            chk("o_ready",     32'(bus.o_ready),     32'(e_ready));
            chk("o_cfg_ready", 32'(bus.o_cfg_ready), 32'(e_ready));
            if (bus.o_valid === 1'b1) got_q.push_back(bus.o_data);
        end
    end

    initial begin
        int base, n;
        cyc(1'b0, 8'h00, 1'b0, 5'd0, 1'b1);
        cyc(1'b0, 8'h00, 1'b0, 5'd0, 1'b1);
        chk_en = 1'b1;
        chk("rst_valid",     32'(bus.o_valid),     0);
        chk("rst_data",      32'(bus.o_data),      0);
        chk("rst_primed",    32'(bus.o_primed),    0);
        chk("rst_ready",     32'(bus.o_ready),     1);
        chk("rst_cfg_ready", 32'(bus.o_cfg_ready), 1);

        // Scenario 1: D=4, samples 1..10
        got_q.delete();
        for (int i = 1; i <= 10; i++) begin
            feed(8'(i));
            if (i == 4) chk("t1_primed_lo", 32'(bus.o_primed), 0);
            if (i == 5) begin
                chk("t1_primed_hi", 32'(bus.o_primed), 1);
                chk("t1_first",     32'(bus.o_data),   1);
            end
        end
        idle(1);
        base = ZF ? 4 : 0;
        chk("t1_count", got_q.size(), 32'(base + 6));
        for (int k = 0; k < got_q.size() && k < base + 6; k++)
            chk("t1_seq", 32'(got_q[k]), (k < base) ? 0 : 32'(k - base + 1));

        // Scenario 4: sample and config together under D=4
        cyc(1'b1, 8'h11, 1'b1, 5'd2, 1'b0);
        chk("t4_valid",     32'(bus.o_valid),     1);
        chk("t4_old_delay", 32'(bus.o_data),      7);
        chk("t4_ready",     32'(bus.o_ready),     0);
        chk("t4_cfg_ready", 32'(bus.o_cfg_ready), 0);
        idle(1);
        feed(8'h22); feed(8'h33); feed(8'h44);
        chk("t4_refill", 32'(bus.o_data),   32'h22);
        chk("t4_primed", 32'(bus.o_primed), 1);

        // Scenario 2: D=0 bypass
        cfg(5'd0);
        feed(8'hA5);
        chk("t2_a5",     32'(bus.o_data),   32'hA5);
        chk("t2_primed", 32'(bus.o_primed), 1);
        feed(8'h3C);
        chk("t2_3c",     32'(bus.o_data),   32'h3C);

        // Scenario 5: D=3 with alternate idle cycles
        cfg(5'd3);
        got_q.delete();
        for (int i = 1; i <= 8; i++) begin
            feed(8'(i));
            idle(1);
        end
        chk("t5_hold_valid", 32'(bus.o_valid), 0);
        chk("t5_hold_data",  32'(bus.o_data),  5);
        n = got_q.size();
        chk("t5_count", n, ZF ? 8 : 5);
        for (int k = 0; k < 5 && n >= 5; k++)
            chk("t5_seq", 32'(got_q[n - 5 + k]), 32'(k + 1));

        // Scenario 3: D=31 across pointer wrap
        cfg(5'd31);
        got_q.delete();
        for (int i = 0; i < 40; i++) feed(8'(i));
        idle(1);
        n = got_q.size();
        chk("t3_count", n, ZF ? 40 : 9);
        for (int k = 0; k < 9 && n >= 9; k++)
            chk("t3_seq", 32'(got_q[n - 9 + k]), 32'(k));

        // Scenario 6: reset in RUN with config and sample pending
        cyc(1'b1, 8'h77, 1'b1, 5'd7, 1'b1);
        chk("t6_valid",     32'(bus.o_valid),     0);
        chk("t6_data",      32'(bus.o_data),      0);
        chk("t6_primed",    32'(bus.o_primed),    0);
        chk("t6_ready",     32'(bus.o_ready),     1);
        chk("t6_cfg_ready", 32'(bus.o_cfg_ready), 1);
        for (int i = 0; i < 5; i++) feed(8'(8'h50 + i));
        chk("t6_default_delay", 32'(bus.o_data), 32'h50);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            logic [4:0] cd;
            cd = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
            cyc(($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 29) == 0), cd,
                ($urandom_range(0, 499) == 0));
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
